// File: rtl/order_failure_flush_controller_if.sv
`default_nettype none
// order_failure_flush_controller_if: failure-detector inputs and flush handshake bundle.
// Defining ORDER_FAILURE_STATS_EN adds the flush_count signal.
interface order_failure_flush_controller_if #(
  parameter int LDQ_SIZE      = 8,
  parameter int ROB_TAG_WIDTH = 5
);
  localparam int c_idx_w = $clog2(LDQ_SIZE);

  logic [LDQ_SIZE-1:0]                    order_failures;
  logic [c_idx_w-1:0]                     ldq_head;
  logic [LDQ_SIZE-1:0][ROB_TAG_WIDTH-1:0] ldq_rob_tag;
  logic                                   flush_ack;
  logic                                   flush_valid;
  logic [ROB_TAG_WIDTH-1:0]               flush_rob_tag;
  logic [c_idx_w-1:0]                     flush_ldq_index;
  logic                                   busy;
`ifdef ORDER_FAILURE_STATS_EN
  logic [31:0]                            flush_count;
`endif

  modport master (
`ifdef ORDER_FAILURE_STATS_EN
    input  flush_count,
`endif
    output order_failures, ldq_head, ldq_rob_tag, flush_ack,
    input  flush_valid, flush_rob_tag, flush_ldq_index, busy
  );

  modport slave (
`ifdef ORDER_FAILURE_STATS_EN
    output flush_count,
`endif
    input  order_failures, ldq_head, ldq_rob_tag, flush_ack,
    output flush_valid, flush_rob_tag, flush_ldq_index, busy
  );
endinterface
`default_nettype wire

// File: rtl/order_failure_flush_controller.sv
`default_nettype none
// order_failure_flush_controller: picks the oldest failing load and issues one flush at a time.
// Optional: ORDER_FAILURE_STATS_EN adds a saturating 32-bit accepted-flush counter.
module order_failure_flush_controller #(
  parameter int LDQ_SIZE      = 8,
  parameter int ROB_TAG_WIDTH = 5,
  parameter int DRAIN_CYCLES  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  order_failure_flush_controller_if.slave bus
);
  localparam int c_idx_w = $clog2(LDQ_SIZE);
  localparam int c_cnt_w = $clog2(DRAIN_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [LDQ_SIZE-1:0]      r_pending, w_pending_nxt;
  logic [c_cnt_w-1:0]       r_cnt, w_cnt_nxt;
  logic [c_idx_w-1:0]       r_idx, w_idx_nxt;
  logic [ROB_TAG_WIDTH-1:0] r_tag, w_tag_nxt;

  logic [LDQ_SIZE-1:0]      w_cand;
  logic [LDQ_SIZE-1:0]      w_older_lat;
  logic [c_idx_w-1:0]       w_age [LDQ_SIZE];
  logic [c_idx_w-1:0]       w_lat_age;
  logic                     w_found;
  logic [c_idx_w-1:0]       w_old_idx;
  logic [c_idx_w-1:0]       w_old_age;
  logic                     w_has_older;

  assign w_cand    = r_pending | bus.order_failures;
  assign w_lat_age = r_idx - bus.ldq_head;

  // Ages are always relative to the live head, so a moving head re-ranks candidates.
  for (genvar i = 0; i < LDQ_SIZE; i++) begin : g_age
    assign w_age[i]       = c_idx_w'(i) - bus.ldq_head;
    assign w_older_lat[i] = (w_age[i] < w_lat_age);
  end

  always_comb begin : p_oldest
    w_found   = 1'b0;
    w_old_idx = '0;
    w_old_age = '0;
    for (int a = LDQ_SIZE - 1; a >= 0; a--) begin
      if (w_cand[bus.ldq_head + c_idx_w'(a)]) begin
        w_found   = 1'b1;
        w_old_idx = bus.ldq_head + c_idx_w'(a);
        w_old_age = c_idx_w'(a);
      end
    end
  end

  assign w_has_older = w_found && (w_old_age < w_lat_age);

  always_comb begin : p_next
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_tag_nxt     = r_tag;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_idx_nxt     = w_old_idx;
          w_tag_nxt     = bus.ldq_rob_tag[w_old_idx];
          w_pending_nxt = w_cand;
          w_state_nxt   = REQ;
        end else begin
          w_pending_nxt = '0;
        end
      end
      REQ: begin
        if (w_has_older) begin
          w_idx_nxt = w_old_idx;
          w_tag_nxt = bus.ldq_rob_tag[w_old_idx];
        end
        if (bus.flush_ack) begin
          // The accepted flush squashes the latched load and everything younger.
          w_pending_nxt = w_cand & w_older_lat;
          if (!w_has_older) begin
            w_cnt_nxt   = c_cnt_w'(DRAIN_CYCLES - 1);
            w_state_nxt = DRAIN;
          end
        end else begin
          w_pending_nxt = w_cand;
        end
      end
      DRAIN: begin
        w_pending_nxt = r_pending | (bus.order_failures & w_older_lat);
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - c_cnt_w'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_tag     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_tag     <= w_tag_nxt;
    end
  end

  assign bus.flush_valid     = (r_state == REQ);
  assign bus.busy            = (r_state != IDLE);
  assign bus.flush_rob_tag   = r_tag;
  assign bus.flush_ldq_index = r_idx;

`ifdef ORDER_FAILURE_STATS_EN
  logic [31:0] r_flush_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flush_count <= '0;
    end else if ((r_state == REQ) && bus.flush_ack && (r_flush_count != '1)) begin
      r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign bus.flush_count = r_flush_count;
`endif

endmodule
`default_nettype wire

// File: doc/order_failure_flush_controller.md
Name: order_failure_flush_controller

Overview:
Sits directly downstream of the LSU order failure detector and consumes its per-load `order_failures` vector each cycle. It accumulates failures into a sticky pending mask and selects the oldest failing load relative to `ldq_head`. It then issues a single flush request, carrying that load's ROB tag, to the ROB/flush logic over a valid/ack handshake. After each accepted flush it holds off for a drain window while the pipeline squashes.

Parameters:
- LDQ_SIZE, 8: load queue entries; must be a power of two ≥ 2; matches lsu_pkg.
- ROB_TAG_WIDTH, 5: width of a ROB tag.
- DRAIN_CYCLES, 2: cycles spent in DRAIN after an ack; must be ≥ 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- order_failures  in  LDQ_SIZE  per-entry failure flags from the detector; sampled every cycle.
- ldq_head  in  $clog2(LDQ_SIZE)  oldest load queue index; the age reference.
- ldq_rob_tag  in  LDQ_SIZE x ROB_TAG_WIDTH (packed array)  ROB tag of each load queue entry.
- flush_ack  in  1  consumer accepts the flush; only meaningful while flush_valid is high.
- flush_valid  out  1  flush request pending.
- flush_rob_tag  out  ROB_TAG_WIDTH  ROB tag to flush from; that instruction and all younger are squashed.
- flush_ldq_index  out  $clog2(LDQ_SIZE)  load queue index of the failing load.
- busy  out  1  high in REQ or DRAIN.

Behaviour:
- Age: age(i) = (i - ldq_head) mod LDQ_SIZE, unsigned, width $clog2(LDQ_SIZE). A smaller age is older; ties are impossible.
- Candidates are `cand = pending | order_failures`, where `pending` is an internal LDQ_SIZE-bit register.
- FSM states: IDLE, REQ, DRAIN. Reset enters IDLE.
- Reset values: pending = 0, DRAIN counter = 0, flush_valid = 0, flush_rob_tag = 0, flush_ldq_index = 0, busy = 0. Reset mid-flush aborts the request with no further output.
- IDLE:
  - If cand ≠ 0: latch the oldest candidate index and its ldq_rob_tag, set pending = cand, and go to REQ.
  - Otherwise pending stays 0.
  - Latency: failure at cycle N gives flush_valid = 1 at N+1.
- REQ:
  - flush_valid = 1 (registered output).
  - Each cycle, pending |= order_failures.
  - Upgrade: if a strictly older candidate than the latched index exists and flush_ack = 0, replace the latched index and tag at the next edge. This is the only payload change permitted while valid is high; the consumer samples the payload on the ack cycle.
  - On flush_ack = 1:
    - Clear in pending the latched index and every entry younger than it.
    - If a candidate strictly older than the latched index is present this cycle, stay in REQ with that candidate latched.
    - Otherwise load the counter with DRAIN_CYCLES-1 and go to DRAIN.
    - flush_valid drops the cycle after ack unless it re-enters REQ.
- DRAIN:
  - flush_valid = 0.
  - Failures from loads strictly older than the last flushed index OR into pending; failures at or younger than it are discarded (squashed).
  - The counter decrements each cycle; at 0, go to IDLE.
- Wrap-around: selection must be correct when the oldest failing entry is numerically larger than a younger one. Example: head = 6, LDQ_SIZE = 8, failures at 1 and 7 → choose 7.
- ldq_head may advance at any time; age is always evaluated with the current ldq_head.
- flush_ack while flush_valid = 0 is ignored.

Optional Feature:
ORDER_FAILURE_STATS_EN:
- When defined, adds output `flush_count` (32 bits, reset 0).
- It increments by 1 on every cycle where flush_valid && flush_ack, and saturates at 2^32-1.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Single failure: head = 0, failures = 8'b0000_0100, tags[2] = 5'd9 for one cycle → next cycle flush_valid = 1, flush_ldq_index = 2, flush_rob_tag = 9. Ack one cycle later → flush_valid = 0, busy = 1 for 2 cycles, then IDLE.
- Wrap-around oldest selection: head = 6, failures = 8'b1000_0010 → flush_ldq_index = 7. After ack, pending bit 1 is cleared because entry 1 is younger than 7, and no second flush occurs.
- Upgrade while waiting: head = 0, failure at 5, ack held low. Then failure at 3 → flush_ldq_index changes 5 → 3 within one cycle. Ack → exactly one handshake, index 3.
- Drain capture: head = 0, flush index 4 acked. During DRAIN, failures at 1 and 6 → after DRAIN a new request appears with index 1; failure 6 is never flushed.
- Reset mid-REQ: assert reset asynchronously while flush_valid = 1 → flush_valid = 0 immediately with no clock edge, and no request after deassert without new failures.
- With ORDER_FAILURE_STATS_EN: three completed handshakes → flush_count = 3; ack while valid is low does not increment.
